pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  Program-counter stage fed by brUnit: holds the architectural PC and computes next-PC from brUnit's
//  branch/offset/jump/target outputs. Drives the fetch address and pc_h4 (PC[31:28]) back to brUnit.
//  Adds stall support: a redirect raised while stalled is latched and applied on the first free cycle.
//  Also keeps a sticky misalignment flag and a count of retired (non-stalled) cycles.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  CNT_W      32             width of retire counter
// PORTS
//  clk              in   1      single system clock, all state updates on rising edge
//  reset            in   1      synchronous, active-high
//  stall            in   1      1 = hold PC this cycle (fetch/decode not ready)
//  branch           in   1      brUnit _branch: taken conditional branch
//  offset           in   32     brUnit _offset: signed byte offset relative to PC+4
//  jump             in   1      brUnit _jump: absolute jump taken
//  target           in   32     brUnit _target: absolute byte address
//  pc               out  32     current PC (fetch address)
//  pc_plus4         out  32     pc + 4, combinational from pc
//  pc_h4            out  4      pc[31:28], to brUnit pc_h4
//  redirect_pending out  1      a redirect is latched awaiting end of stall
//  align_err        out  1      sticky: a redirect address had addr[1:0] != 0
//  retire_cnt       out  CNT_W  count of cycles the PC advanced (stall=0)
// BEHAVIOUR
//  - Reset (sync, high): pc=RESET_PC, redirect_pending=0, pend_addr=0, align_err=0, retire_cnt=0.
//    Reset mid-stall or with pending redirect discards the pending redirect.
//  - Redirect address: jump ? target : pc + 4 + offset (32-bit, wraps mod 2^32). jump beats branch
//    when both are asserted. redir = jump | branch.
//  - Cycle rules, stall=0:
//      redir=1           -> pc <= redir_addr; pending cleared (live redirect beats pending)
//      redir=0, pending  -> pc <= pend_addr; pending cleared
//      otherwise         -> pc <= pc + 4 (wraps 32'hFFFF_FFFC -> 0)
//      retire_cnt <= retire_cnt + 1 (wraps to 0 at all-ones)
//  - Cycle rules, stall=1: pc, retire_cnt hold.
//      redir=1 -> pend_addr <= redir_addr, redirect_pending <= 1 (newest overwrites older pending)
//      redir=0 -> pending state holds
//  - Alignment: every address written to pc or pend_addr has bits [1:0] forced to 0; if the raw
//    redirect address had [1:0]!=0, align_err <= 1 the same edge (stall or not); cleared only by reset.
//  - Latency: redirect visible on pc one edge after branch/jump sampled with stall=0; if stalled,
//    one edge after stall falls. No combinational path from branch/jump/offset/target to pc.
//  - pc_plus4 and pc_h4 are combinational from registered pc only.
// STRUCTURE
//  - Shared package cpu_pkg: RESET_PC default, XLEN=32, INSTR_BYTES=4 constants.
//  - One sub-module pc_next_mux (combinational): inputs pc, branch, offset, jump, target ->
//    redir, redir_addr (aligned), misaligned. pc_unit holds all registers and the stall/pending logic.
// TESTING
//  1 reset=1 one edge, then 4 free cycles -> pc 0,4,8,12,16; retire_cnt=4; pc_h4=0.
//  2 pc=8, branch=1 offset=-4 (32'hFFFF_FFFC) -> next pc=8; offset=32'h10 -> next pc=28.
//  3 pc=32'h1000_0004, jump=1 target=32'h1000_0040 with branch=1 -> pc=32'h1000_0040, pc_h4=1.
//  4 stall=1, jump target=32'h80 then target=32'h90 on next stalled cycle -> pc holds,
//    redirect_pending=1; stall=0 with no redir -> pc=32'h90, pending=0; retire_cnt unchanged while stalled.
//  5 jump target=32'h42 -> pc=32'h40, align_err=1 stays set through later legal redirects until reset.
//  6 pending redirect set, reset=1 -> pc=RESET_PC, redirect_pending=0; pc=32'hFFFF_FFFC free -> pc=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and helpers for the program-counter stage.
package cpu_pkg;

    localparam int          XLEN             = 32;
    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Force an address onto an instruction-word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    // True when the raw address is not on an instruction-word boundary.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational redirect selection: computes the redirect target from brUnit outputs.
module pc_next_mux
    import cpu_pkg::*;
(
    input  logic                   [XLEN-1:0] pc,
    input  logic                              branch,
    input  logic signed            [XLEN-1:0] offset,
    input  logic                              jump,
    input  logic                   [XLEN-1:0] target,
    output logic                              redir,
    output logic                   [XLEN-1:0] redir_addr,
    output logic                              misaligned
);

    logic [XLEN-1:0] raw_addr;

    // Jump wins over branch; branch offset is relative to the sequential PC and wraps mod 2^XLEN.
    always_comb begin
        raw_addr   = jump ? target : (pc + XLEN'(INSTR_BYTES) + $unsigned(offset));
        redir      = jump | branch;
        redir_addr = word_align(raw_addr);
        misaligned = redir & is_misaligned(raw_addr);
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: architectural PC, stall-deferred redirects, sticky
// misalignment flag and retired-cycle counter.
module pc_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     branch,
    input  logic signed [XLEN-1:0]   offset,
    input  logic                     jump,
    input  logic        [XLEN-1:0]   target,
    output logic        [XLEN-1:0]   pc,
    output logic        [XLEN-1:0]   pc_plus4,
    output logic        [3:0]        pc_h4,
    output logic                     redirect_pending,
    output logic                     align_err,
    output logic        [CNT_W-1:0]  retire_cnt
);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic             pend_q, pend_d;
    logic [XLEN-1:0]  pend_addr_q, pend_addr_d;
    logic             align_q, align_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             redir;
    logic [XLEN-1:0]  redir_addr;
    logic             misaligned;

    pc_next_mux u_next_mux (
        .pc         (pc_q),
        .branch     (branch),
        .offset     (offset),
        .jump       (jump),
        .target     (target),
        .redir      (redir),
        .redir_addr (redir_addr),
        .misaligned (misaligned)
    );

    // Next-state: a live redirect beats a pending one; a stalled redirect is parked, newest wins.
    always_comb begin
        pc_d        = pc_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        align_d     = align_q;
        cnt_d       = cnt_q;

        if (misaligned) begin
            align_d = 1'b1;
        end

        if (!stall) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (redir) begin
                pc_d   = redir_addr;
                pend_d = 1'b0;
            end else if (pend_q) begin
                pc_d   = pend_addr_q;
                pend_d = 1'b0;
            end else begin
                pc_d = pc_q + XLEN'(INSTR_BYTES);
            end
        end else if (redir) begin
            pend_addr_d = redir_addr;
            pend_d      = 1'b1;
        end
    end

    // State registers; reset discards any parked redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= word_align(RESET_PC);
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            align_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            align_q     <= align_d;
            cnt_q       <= cnt_d;
        end
    end

    // Outputs are derived from registered state only.
    always_comb begin
        pc               = pc_q;
        pc_plus4         = pc_q + XLEN'(INSTR_BYTES);
        pc_h4            = pc_q[XLEN-1:XLEN-4];
        redirect_pending = pend_q;
        align_err        = align_q;
        retire_cnt       = cnt_q;
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit.
module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch;
    logic signed [31:0] offset;
    logic        jump;
    logic [31:0] target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [3:0]  pc_h4;
    logic        redirect_pending;
    logic        align_err;
    logic [31:0] retire_cnt;

    int checks   = 0;
    int failures = 0;
    logic [31:0] cnt_snap;

    pc_unit #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (32)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .branch           (branch),
        .offset           (offset),
        .jump             (jump),
        .target           (target),
        .pc               (pc),
        .pc_plus4         (pc_plus4),
        .pc_h4            (pc_h4),
        .redirect_pending (redirect_pending),
        .align_err        (align_err),
        .retire_cnt       (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch = 1'b0; offset = '0; jump = 1'b0; target = '0;
        #2;
        tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_pend", 32'(redirect_pending), 32'h0);
        chk("rst_align", 32'(align_err), 32'h0);
        chk("rst_cnt", retire_cnt, 32'h0);
        chk("rst_h4", 32'(pc_h4), 32'h0);
        chk("rst_plus4", pc_plus4, 32'h4);
        reset = 1'b0;

        // Sequential fetch
        tick(); chk("seq_pc1", pc, 32'h4);
        tick(); chk("seq_pc2", pc, 32'h8);
        tick(); chk("seq_pc3", pc, 32'hC);
        tick(); chk("seq_pc4", pc, 32'h10);
        chk("seq_cnt", retire_cnt, 32'd4);
        chk("seq_h4", 32'(pc_h4), 32'h0);
        chk("seq_plus4", pc_plus4, 32'h14);

        // Branch offsets relative to PC+4 (reach pc=8 again via reset)
        reset = 1'b1; tick(); reset = 1'b0;
        tick(); tick();
        chk("br_pre_pc", pc, 32'h8);
        branch = 1'b1; offset = 32'hFFFF_FFFC;
        tick(); chk("br_neg", pc, 32'h8);
        offset = 32'h10;
        tick(); chk("br_pos", pc, 32'h1C);
        branch = 1'b0; offset = '0;

        // Jump beats branch
        jump = 1'b1; target = 32'h1000_0004;
        tick(); chk("jmp_setup", pc, 32'h1000_0004);
        branch = 1'b1; offset = 32'h100; target = 32'h1000_0040;
        tick(); chk("jmp_pri", pc, 32'h1000_0040);
        chk("jmp_h4", 32'(pc_h4), 32'h1);
        branch = 1'b0; jump = 1'b0; offset = '0;

        // Stalled redirects: newest overwrites, applied after stall falls
        cnt_snap = retire_cnt;
        stall = 1'b1; jump = 1'b1; target = 32'h80;
        tick(); chk("stl_hold1", pc, 32'h1000_0040);
        chk("stl_pend1", 32'(redirect_pending), 32'h1);
        target = 32'h90;
        tick(); chk("stl_hold2", pc, 32'h1000_0040);
        chk("stl_pend2", 32'(redirect_pending), 32'h1);
        chk("stl_cnt", retire_cnt, cnt_snap);
        stall = 1'b0; jump = 1'b0; target = '0;
        tick(); chk("stl_apply", pc, 32'h90);
        chk("stl_clear", 32'(redirect_pending), 32'h0);
        chk("stl_cnt_inc", retire_cnt, cnt_snap + 32'd1);

        // Live redirect beats a pending one
        stall = 1'b1; jump = 1'b1; target = 32'h200;
        tick(); chk("live_pend", 32'(redirect_pending), 32'h1);
        stall = 1'b0; target = 32'h300;
        tick(); chk("live_pc", pc, 32'h300);
        chk("live_clear", 32'(redirect_pending), 32'h0);
        jump = 1'b0; target = '0;
        tick(); chk("live_seq", pc, 32'h304);

        // Misaligned redirect: sticky flag
        chk("al_pre", 32'(align_err), 32'h0);
        jump = 1'b1; target = 32'h42;
        tick(); chk("al_pc", pc, 32'h40);
        chk("al_set", 32'(align_err), 32'h1);
        target = 32'h100;
        tick(); chk("al_legal_pc", pc, 32'h100);
        chk("al_sticky", 32'(align_err), 32'h1);
        jump = 1'b0; target = '0;
        tick(); chk("al_sticky2", 32'(align_err), 32'h1);

        // Reset discards pending redirect and clears sticky flag
        stall = 1'b1; jump = 1'b1; target = 32'h500;
        tick(); chk("rp_pend", 32'(redirect_pending), 32'h1);
        reset = 1'b1; jump = 1'b0; target = '0;
        tick(); chk("rp_pc", pc, 32'h0);
        chk("rp_pend_clr", 32'(redirect_pending), 32'h0);
        chk("rp_align_clr", 32'(align_err), 32'h0);
        chk("rp_cnt", retire_cnt, 32'h0);
        reset = 1'b0; stall = 1'b0;
        tick(); chk("rp_seq", pc, 32'h4);

        // PC wrap at top of address space
        jump = 1'b1; target = 32'hFFFF_FFFC;
        tick(); chk("wr_top", pc, 32'hFFFF_FFFC);
        chk("wr_h4", 32'(pc_h4), 32'hF);
        chk("wr_plus4", pc_plus4, 32'h0);
        jump = 1'b0; target = '0;
        tick(); chk("wr_pc", pc, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
